// File: rtl/store_stream_checker_pkg.sv
// Shared definitions for the store stream checker.
//   state_t         : checker FSM states (IDLE, CHECK, REPORT)
//   DEF_TEST_PORT   : default monitored word address
//   DEF_BEGIN_SYM   : default start token that arms a run
//   DEF_TIMEOUT     : default cycle budget for one run
//   ERR_NO_RUN      : error_num value meaning "no run since reset/clear"
//   ERR_SAT         : saturation ceiling of error_num
package store_stream_checker_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam logic [29:0] DEF_TEST_PORT = 30'hFF;
   localparam logic [31:0] DEF_BEGIN_SYM = 32'h168;
   localparam logic [15:0] DEF_TIMEOUT   = 16'hFFFF;

   localparam logic [7:0]  ERR_NO_RUN    = 8'hFF;
   localparam logic [7:0]  ERR_SAT       = 8'hFE;

endpackage

// File: rtl/chk_exp_ram.sv
// Expected-value table: DEPTH x DW, one synchronous write port and one
// asynchronous read port so the checker can compare in the same cycle a
// store is observed.
//   clk   : write clock
//   we    : write strobe
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : combinational read data
module chk_exp_ram #(
   parameter int DW    = 32,
   parameter int DEPTH = 64,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [IW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // NOTE: storage arrays carry no reset; their contents are undefined until
   // written, and a reset branch would turn the array into thousands of flops.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/store_stream_checker.sv
// Store stream checker: watches a store bus for writes to TEST_PORT. A store
// of BEGIN_SYM arms a run; each following store is compared with the next
// entry of a preloaded expected table until check_num entries have been seen
// or the cycle budget runs out, after which the results are held for reading.
//   clk, rst        : clock, asynchronous active-low reset
//   addr/data/wen   : observed store bus
//   exp_we/exp_idx/exp_data : expected-table write port (IDLE only)
//   check_num       : number of entries to check (clamped to DEPTH)
//   clear           : synchronous return to IDLE, error_num <- 255
//   error_num       : mismatch count (saturates at 254, 255 = no run)
//   duration        : cycles spent in CHECK
//   finish          : results valid (REPORT state)
//   timeout         : run ended by the cycle budget
//   first_err_*     : capture of the first mismatch of the run
module store_stream_checker
   import store_stream_checker_pkg::*;
#(
   parameter int            DW        = 32,
   parameter int            AW        = 30,
   parameter int            DEPTH     = 64,
   parameter logic [AW-1:0] TEST_PORT = AW'(DEF_TEST_PORT),
   parameter logic [DW-1:0] BEGIN_SYM = DW'(DEF_BEGIN_SYM),
   parameter logic [15:0]   TIMEOUT   = DEF_TIMEOUT,
   parameter int            IW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] data,
   input  logic          wen,
   input  logic          exp_we,
   input  logic [IW-1:0] exp_idx,
   input  logic [DW-1:0] exp_data,
   input  logic [IW:0]   check_num,
   input  logic          clear,
   output logic [7:0]    error_num,
   output logic [15:0]   duration,
   output logic          finish,
   output logic          timeout,
   output logic          first_err_valid,
   output logic [IW-1:0] first_err_idx,
   output logic [DW-1:0] first_err_exp,
   output logic [DW-1:0] first_err_act
);

   localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH);

   state_t        state, state_nxt;
   logic          hit, hit_q, store_ev;
   logic [IW:0]   idx, idx_nxt, chk_lim;
   logic [15:0]   dur_nxt;
   logic [DW-1:0] exp_val;
   logic          cmp, mismatch, done, budget_hit;

   // A store counts once per rising edge of a qualified write, so a write
   // held across stall cycles is seen only on its first cycle.
   assign hit      = wen && (addr == TEST_PORT);
   assign store_ev = hit && !hit_q;

   assign chk_lim  = (check_num > DEPTH_L) ? DEPTH_L : check_num;

   assign cmp      = (state == CHECK) && store_ev && (idx < chk_lim);
   assign mismatch = cmp && (data != exp_val);
   assign idx_nxt  = idx + {{IW{1'b0}}, cmp};
   assign dur_nxt  = duration + 16'd1;
   assign done     = (idx == chk_lim);
   // Judged after this cycle's compare, so a final store landing on the
   // budget cycle completes the run normally instead of timing out.
   assign budget_hit = (dur_nxt == TIMEOUT) && (idx_nxt < chk_lim);

   assign finish   = (state == REPORT);

   chk_exp_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_ram (
      .clk   (clk),
      .we    (exp_we && (state == IDLE)),
      .waddr (exp_idx),
      .wdata (exp_data),
      .raddr (idx[IW-1:0]),
      .rdata (exp_val)
   );

   // NOTE: sequential blocks use non-blocking assignments only, so every
   // register samples the values from before the clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // NOTE: the default assignment up front keeps this block from inferring
   // a latch on paths that do not name state_nxt.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (store_ev && (data == BEGIN_SYM)) state_nxt = CHECK;
         CHECK:   if (done || budget_hit)              state_nxt = REPORT;
         REPORT:  state_nxt = REPORT;
         default: state_nxt = IDLE;
      endcase
      if (clear) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_q           <= 1'b0;
         idx             <= '0;
         error_num       <= ERR_NO_RUN;
         duration        <= '0;
         timeout         <= 1'b0;
         first_err_valid <= 1'b0;
         first_err_idx   <= '0;
         first_err_exp   <= '0;
         first_err_act   <= '0;
      end else begin
         hit_q <= hit;
         if (clear) begin
            error_num <= ERR_NO_RUN;
         end else begin
            case (state)
               IDLE: begin
                  if (state_nxt == CHECK) begin
                     idx             <= '0;
                     error_num       <= '0;
                     duration        <= '0;
                     timeout         <= 1'b0;
                     first_err_valid <= 1'b0;
                  end
               end
               CHECK: begin
                  duration <= dur_nxt;
                  idx      <= idx_nxt;
                  if (mismatch) begin
                     if (error_num < ERR_SAT) error_num <= error_num + 8'd1;
                     if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= idx[IW-1:0];
                        first_err_exp   <= exp_val;
                        first_err_act   <= data;
                     end
                  end
                  if (budget_hit) timeout <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_store_stream_checker.sv
// Self-checking bench for store_stream_checker. Three instances share the
// store bus: u_main (defaults), u_to (TIMEOUT=100) and u_big (DEPTH=512).
// Instances not under test are held in clear. Expected results come from a
// list-level model: compare the first min(check_num,DEPTH) stores after the
// start token against the table, count mismatches with saturation, and note
// the first one.
module tb_store_stream_checker;
   import store_stream_checker_pkg::*;

   localparam logic [29:0] TP  = DEF_TEST_PORT;
   localparam logic [31:0] BEG = DEF_BEGIN_SYM;
   localparam logic [31:0] END_TOK = 32'h0000_0E4D;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [29:0] addr = '0;
   logic [31:0] data = '0;
   logic        wen = 1'b0;
   logic [8:0]  exp_idx = '0;
   logic [31:0] exp_data = '0;
   logic [9:0]  check_num = '0;
   logic exp_we_m = 1'b0, exp_we_t = 1'b0, exp_we_b = 1'b0;
   logic clr_m = 1'b1, clr_t = 1'b1, clr_b = 1'b1;

   logic [7:0]  err_m, err_t, err_b;
   logic [15:0] dur_m, dur_t, dur_b;
   logic        fin_m, fin_t, fin_b, to_m, to_t, to_b, fev_m, fev_t, fev_b;
   logic [5:0]  fidx_m, fidx_t;
   logic [8:0]  fidx_b;
   logic [31:0] fexp_m, fexp_t, fexp_b, fact_m, fact_t, fact_b;

   store_stream_checker u_main (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
      .exp_we(exp_we_m), .exp_idx(exp_idx[5:0]), .exp_data(exp_data),
      .check_num(check_num[6:0]), .clear(clr_m),
      .error_num(err_m), .duration(dur_m), .finish(fin_m), .timeout(to_m),
      .first_err_valid(fev_m), .first_err_idx(fidx_m),
      .first_err_exp(fexp_m), .first_err_act(fact_m));

   store_stream_checker #(.TIMEOUT(16'd100)) u_to (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
      .exp_we(exp_we_t), .exp_idx(exp_idx[5:0]), .exp_data(exp_data),
      .check_num(check_num[6:0]), .clear(clr_t),
      .error_num(err_t), .duration(dur_t), .finish(fin_t), .timeout(to_t),
      .first_err_valid(fev_t), .first_err_idx(fidx_t),
      .first_err_exp(fexp_t), .first_err_act(fact_t));

   store_stream_checker #(.DEPTH(512)) u_big (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
      .exp_we(exp_we_b), .exp_idx(exp_idx), .exp_data(exp_data),
      .check_num(check_num), .clear(clr_b),
      .error_num(err_b), .duration(dur_b), .finish(fin_b), .timeout(to_b),
      .first_err_valid(fev_b), .first_err_idx(fidx_b),
      .first_err_exp(fexp_b), .first_err_act(fact_b));

   // View of the instance under test.
   int          sel = 0;
   logic [7:0]  o_err;
   logic [15:0] o_dur;
   logic        o_fin, o_to, o_fev;
   logic [8:0]  o_fidx;
   logic [31:0] o_fexp, o_fact;
   always_comb begin
      o_err = err_m; o_dur = dur_m; o_fin = fin_m; o_to = to_m; o_fev = fev_m;
      o_fidx = {3'b0, fidx_m}; o_fexp = fexp_m; o_fact = fact_m;
      if (sel == 1) begin
         o_err = err_t; o_dur = dur_t; o_fin = fin_t; o_to = to_t; o_fev = fev_t;
         o_fidx = {3'b0, fidx_t}; o_fexp = fexp_t; o_fact = fact_t;
      end else if (sel == 2) begin
         o_err = err_b; o_dur = dur_b; o_fin = fin_b; o_to = to_b; o_fev = fev_b;
         o_fidx = fidx_b; o_fexp = fexp_b; o_fact = fact_b;
      end
   end

   int total = 0;
   int bad   = 0;
   logic [31:0] tbl [512];
   logic [31:0] stim [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic set_clear(input int inst);
      clr_m = (inst != 0);
      clr_t = (inst != 1);
      clr_b = (inst != 2);
   endtask

   task automatic load_table(input int inst, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         exp_idx  = 9'(i);
         exp_data = tbl[i];
         exp_we_m = (inst == 0);
         exp_we_t = (inst == 1);
         exp_we_b = (inst == 2);
      end
      @(negedge clk);
      exp_we_m = 1'b0; exp_we_t = 1'b0; exp_we_b = 1'b0;
   endtask

   // Drive one store held for 'hold' cycles; ev_cyc marks its sampling edge.
   task automatic store(input logic [31:0] v, input int hold, output int ev_cyc);
      @(negedge clk);
      addr = TP; data = v; wen = 1'b1;
      ev_cyc = cyc;
      repeat (hold) @(negedge clk);
      wen = 1'b0;
   endtask

   task automatic idle(input int n, input bit noise);
      repeat (n) begin
         @(negedge clk);
         if (noise && ($urandom_range(1) == 1)) begin
            addr = TP ^ 30'(1 + $urandom_range(100));
            data = $urandom;
            wen  = 1'b1;
         end else begin
            wen = 1'b0;
         end
      end
      @(negedge clk);
      wen = 1'b0;
   endtask

   task automatic wait_finish(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (o_fin) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic fill_fib();
      int a, b, t;
      int fib [16];
      a = 0; b = 1;
      for (int i = 0; i < 16; i++) begin
         fib[i] = a; t = a + b; a = b; b = t;
      end
      for (int i = 0; i < 16; i++) tbl[i] = 32'(fib[i]);
      for (int i = 16; i < 32; i++) tbl[i] = 32'(fib[31 - i]);
      tbl[32] = END_TOK;
      stim.delete();
      for (int i = 0; i < 33; i++) stim.push_back(tbl[i]);
   endtask

   task automatic run(input string tag, input int inst, input int chk_req,
                      input int hmin, input int hmax, input int gmax,
                      input bit noise, input bit reload);
      int depth, chk, ncmp, errs, first, c0, clast, c, dexp;
      bit to_exp, ok;
      logic [7:0] err_keep;
      sel   = inst;
      depth = (inst == 2) ? 512 : 64;
      set_clear(inst);
      if (reload) load_table(inst, depth);
      check_num = 10'(chk_req);
      chk    = (chk_req > depth) ? depth : chk_req;
      ncmp   = (stim.size() < chk) ? stim.size() : chk;
      to_exp = (stim.size() < chk);
      errs = 0; first = -1;
      for (int i = 0; i < ncmp; i++) begin
         if (stim[i] !== tbl[i]) begin
            errs = (errs < 254) ? errs + 1 : 254;
            if (first < 0) first = i;
         end
      end
      store(BEG, hmin + $urandom_range(hmax - hmin), c0);
      clast = c0;
      foreach (stim[i]) begin
         idle($urandom_range(gmax), noise);
         store(stim[i], hmin + $urandom_range(hmax - hmin), c);
         if (i == chk - 1) clast = c;
      end
      wait_finish(300, ok);
      check({tag, " finish"}, ok, 1);
      check({tag, " error_num"}, o_err, errs);
      check({tag, " timeout"}, o_to, to_exp);
      check({tag, " first_err_valid"}, o_fev, first >= 0);
      if (first >= 0) begin
         check({tag, " first_err_idx"}, o_fidx, first);
         check({tag, " first_err_exp"}, o_fexp, tbl[first]);
         check({tag, " first_err_act"}, o_fact, stim[first]);
      end
      dexp = to_exp ? 100 : (clast - c0 + 1);
      check({tag, " duration"}, o_dur, dexp);
      // Results hold in REPORT even when more stores arrive.
      err_keep = o_err;
      store(~BEG, 1, c);
      idle(2, 1'b0);
      check({tag, " hold err"}, o_err, err_keep);
      check({tag, " hold finish"}, o_fin, 1);
      set_clear(-1);
      @(negedge clk);
      @(negedge clk);
      check({tag, " clr err"}, o_err, 8'hFF);
      check({tag, " clr finish"}, o_fin, 0);
   endtask

   initial begin
      int c, c0;
      bit ok;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      sel = 0;
      check("rst error_num", o_err, 8'hFF);
      check("rst duration", o_dur, 0);
      check("rst finish", o_fin, 0);
      check("rst timeout", o_to, 0);
      check("rst first_err_valid", o_fev, 0);
      check("rst first_err_idx", o_fidx, 0);
      check("rst first_err_exp", o_fexp, 0);
      check("rst first_err_act", o_fact, 0);

      fill_fib();
      run("fib_ok", 0, 33, 1, 1, 1, 1'b0, 1'b1);

      fill_fib();
      stim[16] = 32'd611;
      run("fib_bad16", 0, 33, 1, 2, 2, 1'b0, 1'b0);
      check("fib_bad16 idx const", o_fidx, 16);
      check("fib_bad16 exp const", o_fexp, 610);
      check("fib_bad16 act const", o_fact, 611);

      fill_fib();
      run("hold3", 0, 33, 3, 3, 1, 1'b0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         int chk_req, chk, n;
         chk_req = (r == 0) ? 70 : (r == 1) ? 0 : $urandom_range(80);
         chk = (chk_req > 64) ? 64 : chk_req;
         n = chk + $urandom_range(3);
         for (int i = 0; i < 64; i++) tbl[i] = $urandom;
         stim.delete();
         for (int i = 0; i < n; i++)
            stim.push_back(($urandom_range(3) == 0) ? 32'($urandom) : tbl[i % 64]);
         run($sformatf("rand%0d", r), 0, chk_req, 1, 3, 3, 1'b1, 1'b1);
      end

      // Clear in the middle of a run returns to IDLE with no report.
      sel = 0;
      set_clear(0);
      check_num = 10'd20;
      store(BEG, 1, c);
      store(32'h1234, 1, c);
      clr_m = 1'b1;
      @(negedge clk);
      clr_m = 1'b0;
      check("midclr err", o_err, 8'hFF);
      check("midclr finish", o_fin, 0);
      store(32'h5678, 2, c);
      idle(3, 1'b0);
      check("midclr stays idle err", o_err, 8'hFF);
      check("midclr stays idle finish", o_fin, 0);
      set_clear(-1);

      fill_fib();
      stim = stim[0:4];
      run("budget", 1, 33, 1, 2, 2, 1'b0, 1'b1);

      // Final compare lands on the budget cycle: no timeout, one extra cycle.
      sel = 1;
      set_clear(1);
      check_num = 10'd1;
      store(BEG, 1, c0);
      while (cyc != c0 + 100) @(negedge clk);
      addr = TP; data = tbl[0]; wen = 1'b1;
      @(negedge clk);
      wen = 1'b0;
      wait_finish(20, ok);
      check("edge finish", ok, 1);
      check("edge timeout", o_to, 0);
      check("edge duration", o_dur, 101);
      check("edge error_num", o_err, 0);
      set_clear(-1);

      for (int i = 0; i < 300; i++) tbl[i] = $urandom;
      stim.delete();
      for (int i = 0; i < 300; i++) stim.push_back(tbl[i] ^ 32'(1 + $urandom_range(1000)));
      run("sat", 2, 300, 1, 1, 0, 1'b0, 1'b1);

      // Table writes during CHECK are dropped; contents survive clear.
      sel = 2;
      set_clear(2);
      check_num = 10'd4;
      store(BEG, 1, c);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_idx = 9'(i); exp_data = ~tbl[i]; exp_we_b = 1'b1;
      end
      @(negedge clk);
      exp_we_b = 1'b0;
      for (int i = 0; i < 4; i++) store(tbl[i], 1, c);
      wait_finish(20, ok);
      check("we_in_check finish", ok, 1);
      check("we_in_check error_num", o_err, 0);
      check("we_in_check first_err_valid", o_fev, 0);
      set_clear(-1);

      // Reset during CHECK aborts the run.
      sel = 0;
      set_clear(0);
      check_num = 10'd10;
      store(BEG, 1, c);
      store(32'hDEAD, 1, c);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid err", o_err, 8'hFF);
      check("rst_mid duration", o_dur, 0);
      check("rst_mid first_err_valid", o_fev, 0);
      rst = 1'b1;
      idle(4, 1'b0);
      check("rst_mid no report", o_fin, 0);
      set_clear(-1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/store_stream_checker.md
STORE_STREAM_CHECKER -- requirements
Module: store_stream_checker

Interface
REQ-001 Parameters SHALL be: DW 32, data width; AW 30, word-address width; DEPTH 64, maximum expected entries; TEST_PORT 30'hFF, monitored address; BEGIN_SYM 32'h168, start token; TIMEOUT 16'hFFFF, cycle budget.
REQ-002 Ports SHALL be:
  - clk  in  1  clock.
  - rst  in  1  asynchronous, active-low reset.
  - addr  in  AW  observed store address.
  - data  in  DW  observed store data.
  - wen  in  1  observed store enable.
  - exp_we  in  1  expected-table write strobe.
  - exp_idx  in  log2(DEPTH)  table index.
  - exp_data  in  DW  expected value.
  - check_num  in  log2(DEPTH)+1  entries to check.
  - clear  in  1  synchronous return to IDLE.
  - error_num  out  8  mismatch count.
  - duration  out  16  cycles spent in CHECK.
  - finish  out  1  report valid.
  - timeout  out  1  run aborted by budget.
  - first_err_valid  out  1  a mismatch has been captured.
  - first_err_idx  out  log2(DEPTH)  index of first mismatch.
  - first_err_exp  out  DW  expected value at first mismatch.
  - first_err_act  out  DW  actual value at first mismatch.

Function
REQ-003 States SHALL be IDLE, CHECK, REPORT.
REQ-004 A store event SHALL be the rising edge of (wen && addr==TEST_PORT), detected against the registered previous value; wen held high across stall cycles SHALL count once.
REQ-005 IDLE -> CHECK SHALL occur on a store event with data==BEGIN_SYM; the begin store SHALL NOT be compared.
REQ-006 On entry to CHECK, the block SHALL set error_num=0, duration=0, idx=0, timeout=0 and first_err_valid=0.
REQ-007 In CHECK, each store event SHALL compare data with table[idx]; a mismatch SHALL increment error_num; idx SHALL increment by 1.
REQ-008 error_num SHALL saturate at 254; 255 SHALL mean "no run since reset/clear".
REQ-009 The first mismatch of a run SHALL latch idx, the expected value and the actual value, and set first_err_valid; later mismatches SHALL NOT overwrite the capture.
REQ-010 duration SHALL increment every CHECK cycle.
REQ-011 CHECK -> REPORT SHALL occur the cycle after idx reaches check_num; with check_num==0, the transition SHALL occur the cycle after entry.
REQ-012 CHECK -> REPORT with timeout=1 SHALL occur when duration==TIMEOUT and idx<check_num; if the final compare and the timeout fall in the same cycle, the compare SHALL complete and timeout SHALL stay 0.
REQ-013 check_num greater than DEPTH SHALL be clamped to DEPTH.
REQ-014 In REPORT, finish SHALL be 1 and all result outputs SHALL hold; store events SHALL be ignored.
REQ-015 clear SHALL move any state to IDLE next cycle and set error_num=255; the table contents SHALL be preserved.
REQ-016 exp_we SHALL write table[exp_idx] only in IDLE; it SHALL be ignored otherwise.
REQ-017 Table reads SHALL be combinational or pre-fetched so that the compare happens in the same cycle as the store event, with no added latency.

Reset
REQ-018 rst low SHALL force IDLE and set error_num=255, duration=0, finish=0, timeout=0, first_err_valid=0, first_err_idx=0, first_err_exp=0, first_err_act=0, idx=0, and clear the edge-detect register to 0.
REQ-019 Table contents SHALL be undefined after reset.
REQ-020 Reset asserted mid-CHECK SHALL abort the run with no report.

Structure
REQ-021 A shared package SHALL hold the state enum and the default constants TEST_PORT, BEGIN_SYM and TIMEOUT.
REQ-022 The expected table SHALL be a sub-module chk_exp_ram (DEPTH x DW, one write port, one asynchronous read port).

Verification
REQ-023 Load the Fibonacci up/down table of 32 entries plus END token; check_num=33; store BEGIN then the 33 correct values -> finish=1, error_num=0, first_err_valid=0, timeout=0.
REQ-024 Same run with entry 16 stored as 611 -> error_num=1, first_err_idx=16, first_err_exp=610, first_err_act=611.
REQ-025 Hold wen high for 3 cycles on each store -> each store counted once, error_num=0, idx=33 at REPORT.
REQ-026 TIMEOUT=100 with only 5 stores after BEGIN -> finish=1, timeout=1, duration=100.
REQ-027 300 mismatching stores with DEPTH=512 -> error_num=254; then clear -> IDLE and error_num=255; then exp_we during CHECK -> table unchanged.
